// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and response-entry layout shared by the ALU responder and its benches; ALU_OVF_EN adds the overflow bit
package alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
`ifdef ALU_OVF_EN
  localparam int OVF_W = 1;
`else
  localparam int OVF_W = 0;
`endif
  // Entry layout, LSB first: z[w], tag[tagw], ex, err, then ovf when enabled
  function automatic int rsp_entry_w(input int w, input int tagw);
    return w + tagw + 2 + OVF_W;
  endfunction
endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: parameterised synchronous FIFO with combinational head, power-of-two depth
module alu_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/alu_responder.sv
// alu_responder: valid/ready ALU service end with one operand stage and a response FIFO
// Build option: define ALU_OVF_EN to add the per-response signed overflow flag rsp_ovf.
module alu_responder
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAGW  = 4,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [W-1:0]    req_a,
  input  logic [W-1:0]    req_b,
  input  logic [2:0]      req_op,
  input  logic [TAGW-1:0] req_tag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_z,
  output logic            rsp_ex,
  output logic            rsp_err,
  output logic [TAGW-1:0] rsp_tag
`ifdef ALU_OVF_EN
  ,
  output logic            rsp_ovf
`endif
);
  localparam int EW = rsp_entry_w(W, TAGW);
  localparam int CW = $clog2(DEPTH) + 1;
  logic            s1_valid_q, s1_valid_d;
  logic [W-1:0]    s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [2:0]      s1_op_q, s1_op_d;
  logic [TAGW-1:0] s1_tag_q, s1_tag_d;
  logic [EW-1:0]   last_q, last_d, push_data, head, out;
  logic [CW-1:0]   count;
  logic            full, empty, accept, pop;
  logic [W-1:0]    sum, diff, z;
  logic            ex, err;
`ifdef ALU_OVF_EN
  logic            ovf;
`endif
  // Credit covers the result already in flight in S1, so S1 can always push
  assign req_ready = (count + CW'(s1_valid_q)) < CW'(DEPTH);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = !empty;
  assign pop       = rsp_valid && rsp_ready;
  always_comb begin
    sum  = s1_a_q + s1_b_q;
    diff = s1_a_q - s1_b_q;
    z = s1_op_q == OP_AND ? s1_a_q & s1_b_q :
        s1_op_q == OP_OR  ? s1_a_q | s1_b_q :
        s1_op_q == OP_ADD ? sum :
        s1_op_q == OP_SUB ? diff :
        s1_op_q == OP_SLT ? {{(W-1){1'b0}}, $signed(s1_a_q) < $signed(s1_b_q)} : '0;
    err = !(s1_op_q inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT});
    ex  = z == '0;
`ifdef ALU_OVF_EN
    ovf = (s1_op_q == OP_ADD && s1_a_q[W-1] == s1_b_q[W-1] && sum[W-1] != s1_a_q[W-1]) ||
          (s1_op_q == OP_SUB && s1_a_q[W-1] != s1_b_q[W-1] && diff[W-1] != s1_a_q[W-1]);
    push_data = {ovf, err, ex, s1_tag_q, z};
`else
    push_data = {err, ex, s1_tag_q, z};
`endif
  end
  alu_rsp_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s1_valid_q && !full),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  // Outputs show the last consumed entry while the FIFO is empty
  always_comb begin
    s1_valid_d = accept;
    s1_a_d     = accept ? req_a : s1_a_q;
    s1_b_d     = accept ? req_b : s1_b_q;
    s1_op_d    = accept ? req_op : s1_op_q;
    s1_tag_d   = accept ? req_tag : s1_tag_q;
    last_d     = pop ? head : last_q;
    out        = empty ? last_q : head;
  end
  assign rsp_z   = out[W-1:0];
  assign rsp_tag = out[W+TAGW-1:W];
  assign rsp_ex  = out[W+TAGW];
  assign rsp_err = out[W+TAGW+1];
`ifdef ALU_OVF_EN
  assign rsp_ovf = out[EW-1];
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      last_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      last_q     <= last_d;
    end
  end
endmodule

// File: tb/tb_alu_responder.sv
// tb_alu_responder: randomized self-checking bench for alu_responder against an arithmetic reference model
module tb_alu_responder;
  localparam int DEPTH = 2;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0, req_b = '0;
  logic [2:0]  req_op = '0;
  logic [3:0]  req_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_z;
  logic        rsp_ex, rsp_err;
  logic [3:0]  rsp_tag;
`ifdef ALU_OVF_EN
  logic        rsp_ovf;
`endif

  alu_responder #(.W(32), .TAGW(4), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_ex    (rsp_ex),
    .rsp_err   (rsp_err),
    .rsp_tag   (rsp_tag)
`ifdef ALU_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] z;
    logic        ex;
    logic        err;
    logic        ovf;
    logic [3:0]  tag;
    int          vis;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_acc = 0;
  bit   last_acc;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [3:0] tag);
    exp_t e;
    longint sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    e = '{default: 0};
    e.tag = tag;
    case (op)
      3'd0: e.z = a & b;
      3'd1: e.z = a | b;
      3'd2: begin r = sa + sb; e.z = a + b; e.ovf = r > 64'sd2147483647 || r < -64'sd2147483648; end
      3'd6: begin r = sa - sb; e.z = a - b; e.ovf = r > 64'sd2147483647 || r < -64'sd2147483648; end
      3'd7: e.z = (sa < sb) ? 32'd1 : 32'd0;
      default: e.err = 1'b1;
    endcase
    e.ex = e.z == 32'd0;
    return e;
  endfunction

  // One clock: check outputs against the model, record handshakes, advance past the edge
  task automatic cycle();
    bit   ev, acc, pop;
    exp_t e;
    ev = q.size() > 0 && cyc >= q[0].vis;
    checks++;
    if (req_ready !== (q.size() < DEPTH)) begin
      errors++;
      $display("FAIL req_ready cyc=%0d: got %b want %b", cyc, req_ready, q.size() < DEPTH);
    end
    checks++;
    if (rsp_valid !== ev) begin
      errors++;
      $display("FAIL rsp_valid cyc=%0d: got %b want %b", cyc, rsp_valid, ev);
    end
    e = ev ? q[0] : last_exp;
    checks++;
    if ({rsp_z, rsp_ex, rsp_err, rsp_tag} !== {e.z, e.ex, e.err, e.tag}) begin
      errors++;
      $display("FAIL payload cyc=%0d: got z=%h ex=%b err=%b tag=%h want z=%h ex=%b err=%b tag=%h",
               cyc, rsp_z, rsp_ex, rsp_err, rsp_tag, e.z, e.ex, e.err, e.tag);
    end
`ifdef ALU_OVF_EN
    checks++;
    if (rsp_ovf !== e.ovf) begin
      errors++;
      $display("FAIL ovf cyc=%0d: got %b want %b", cyc, rsp_ovf, e.ovf);
    end
`endif
    acc = req_valid && req_ready;
    pop = rsp_valid && rsp_ready;
    if (pop && q.size() > 0) begin
      last_exp = q[0];
      void'(q.pop_front());
    end
    if (acc) begin
      e = model(req_a, req_b, req_op, req_tag);
      e.vis = cyc + 2;
      q.push_back(e);
      n_acc++;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    reset = 1'b0;
    req_valid = 1'b0;
    q.delete();
    last_exp = '{default: 0};
  endtask

  task automatic randomize_req();
    req_a   = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom();
    req_b   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom();
    req_op  = 3'($urandom_range(0, 7));
    req_tag = 4'($urandom_range(0, 15));
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [3:0] tag);
    int k;
    req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!last_acc && k < 50);
    req_valid = 1'b0;
    if (!last_acc) begin
      checks++; errors++;
      $display("FAIL send timeout: got no accept want accept tag=%h", tag);
    end
  endtask

  task automatic drain();
    int k;
    rsp_ready = 1'b1;
    k = 0;
    while (q.size() > 0 && k < 100) begin
      cycle();
      k++;
    end
    cycle();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain timeout: got %0d left want 0", q.size());
    end
  endtask

  task automatic test_reset();
    req_valid = 1'b1;
    randomize_req();
    do_reset(2);
    repeat (4) cycle();
  endtask

  task automatic test_ops();
    rsp_ready = 1'b1;
    send(32'd5, 32'd3, 3'b000, 4'd1);
    send(32'd5, 32'd3, 3'b001, 4'd2);
    send(32'd5, 32'd3, 3'b010, 4'd3);
    send(32'd5, 32'd3, 3'b110, 4'd4);
    send(32'd5, 32'd3, 3'b111, 4'd5);
    send(32'd3, 32'd3, 3'b110, 4'd6);
    send(32'hFFFF_FFFF, 32'd0, 3'b111, 4'd7);
    drain();
  endtask

  task automatic test_illegal();
    send(32'd12, 32'd34, 3'b011, 4'd9);
    send(32'd1, 32'd2, 3'b100, 4'd10);
    send(32'd1, 32'd2, 3'b101, 4'd11);
    drain();
  endtask

  task automatic test_backpressure();
    int n0;
    rsp_ready = 1'b0;
    n0 = n_acc;
    randomize_req();
    req_valid = 1'b1;
    repeat (6) begin
      cycle();
      if (last_acc) randomize_req();
    end
    req_valid = 1'b0;
    checks++;
    if (n_acc - n0 != DEPTH) begin
      errors++;
      $display("FAIL backpressure accepts: got %0d want %0d", n_acc - n0, DEPTH);
    end
    drain();
  endtask

  task automatic test_stream(input int n, input bit rand_ready);
    int n0, k;
    n0 = n_acc;
    k = 0;
    rsp_ready = 1'b1;
    randomize_req();
    req_valid = 1'b1;
    while (n_acc - n0 < n && k < 20 * n) begin
      if (rand_ready) rsp_ready = $urandom_range(0, 1) == 1;
      cycle();
      if (last_acc) randomize_req();
      k++;
    end
    req_valid = 1'b0;
    checks++;
    if (n_acc - n0 != n) begin
      errors++;
      $display("FAIL stream accepts: got %0d want %0d", n_acc - n0, n);
    end
    drain();
  endtask

`ifdef ALU_OVF_EN
  task automatic test_ovf();
    send(32'h7FFF_FFFF, 32'd1, 3'b010, 4'd1);
    send(32'h8000_0000, 32'd1, 3'b110, 4'd2);
    send(32'd1, 32'd1, 3'b010, 4'd3);
    drain();
  endtask
`endif

  task automatic test_midreset();
    rsp_ready = 1'b0;
    send(32'd1, 32'd2, 3'b010, 4'd4);
    send(32'd6, 32'd2, 3'b110, 4'd5);
    req_valid = 1'b1;
    randomize_req();
    cycle();
    do_reset(1);
    rsp_ready = 1'b1;
    repeat (4) cycle();
    send(32'd9, 32'd4, 3'b001, 4'd6);
    drain();
  endtask

  initial begin
    last_exp = '{default: 0};
    test_reset();
    test_ops();
    test_illegal();
    test_backpressure();
    test_stream(10, 1'b0);
    test_stream(30, 1'b1);
`ifdef ALU_OVF_EN
    test_ovf();
`endif
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end
endmodule
